// File: rtl/hyper_desc_pkg.sv
// -----------------------------------------------------------------------------
// hyper_desc_pkg
// Shared constants, types and small helpers for the DMA descriptor table and
// the hyper_desc_arbiter that owns it.
//   DATA_W          descriptor width (64)
//   DESC_ENTRIES    number of descriptors in the table (8)
//   DESC_ACTIVE_BIT descriptor still active; a completed write-back clears it
//   DESC_OWN_BIT    ownership/generation bit checked on scheduler write-back
// -----------------------------------------------------------------------------
package hyper_desc_pkg;

    localparam int DATA_W          = 64;
    localparam int DESC_ENTRIES    = 8;
    localparam int IDX_W           = $clog2(DESC_ENTRIES);
    localparam int DESC_ACTIVE_BIT = 63;
    localparam int DESC_OWN_BIT    = 61;

    typedef logic [DATA_W-1:0]       desc_t;
    typedef logic [IDX_W-1:0]        idx_t;
    typedef logic [DESC_ENTRIES-1:0] done_t;

    // CPU access granted at the current edge.
    typedef enum logic [1:0] {
        CPU_NONE = 2'd0,
        CPU_RD   = 2'd1,
        CPU_WR   = 2'd2
    } cpu_op_e;

    function automatic logic desc_owner(input desc_t d);
        return d[DESC_OWN_BIT];
    endfunction

    function automatic logic desc_active(input desc_t d);
        return d[DESC_ACTIVE_BIT];
    endfunction

endpackage

// File: rtl/hyper_desc_arbiter_if.sv
// -----------------------------------------------------------------------------
// hyper_desc_arbiter_if
// Bundles the scheduler port, the CPU port and the IRQ/completion signals of
// the descriptor arbiter.
//   Scheduler : S_READ/S_R_ADDR -> S_R_DATA, S_WRITE/S_W_ADDR/S_W_DATA,
//               S_IRQ/S_IRQ_DESC
//   CPU       : C_REQ/C_WE/C_ADDR/C_WDATA -> C_ACK/C_RDATA,
//               C_DONE/C_DONE_CLR, C_IRQ_PEND/C_IRQ_DESC/C_IRQ_POP/C_IRQ_OVF
// modport master : scheduler + CPU side (drives requests)
// modport slave  : the arbiter
// -----------------------------------------------------------------------------
interface hyper_desc_arbiter_if;
    import hyper_desc_pkg::*;

    // Scheduler side
    logic  S_READ;
    idx_t  S_R_ADDR;
    desc_t S_R_DATA;
    logic  S_WRITE;
    idx_t  S_W_ADDR;
    desc_t S_W_DATA;
    logic  S_IRQ;
    idx_t  S_IRQ_DESC;

    // CPU side
    logic  C_REQ;
    logic  C_WE;
    idx_t  C_ADDR;
    desc_t C_WDATA;
    logic  C_ACK;
    desc_t C_RDATA;
    done_t C_DONE;
    done_t C_DONE_CLR;
    logic  C_IRQ_PEND;
    idx_t  C_IRQ_DESC;
    logic  C_IRQ_POP;
    logic  C_IRQ_OVF;

    modport master (
        output S_READ, S_R_ADDR, S_WRITE, S_W_ADDR, S_W_DATA, S_IRQ, S_IRQ_DESC,
        output C_REQ, C_WE, C_ADDR, C_WDATA, C_DONE_CLR, C_IRQ_POP,
        input  S_R_DATA, C_ACK, C_RDATA, C_DONE, C_IRQ_PEND, C_IRQ_DESC, C_IRQ_OVF
    );

    modport slave (
        input  S_READ, S_R_ADDR, S_WRITE, S_W_ADDR, S_W_DATA, S_IRQ, S_IRQ_DESC,
        input  C_REQ, C_WE, C_ADDR, C_WDATA, C_DONE_CLR, C_IRQ_POP,
        output S_R_DATA, C_ACK, C_RDATA, C_DONE, C_IRQ_PEND, C_IRQ_DESC, C_IRQ_OVF
    );

endinterface

// File: rtl/hyper_irq_fifo.sv
// -----------------------------------------------------------------------------
// hyper_irq_fifo
// Small FIFO of scheduler interrupt descriptors read by the CPU.
//   CLK, RST   clock, synchronous active-low reset
//   push       enqueue push_desc (dropped and flagged when full without pop)
//   push_desc  descriptor index to enqueue
//   pop        drop the head entry (ignored when empty); clears ovf
//   pend       FIFO not empty
//   head       oldest entry (0 while empty)
//   ovf        sticky overflow flag
// Parameter IRQ_DEPTH: power of two, 2..16.
// -----------------------------------------------------------------------------
module hyper_irq_fifo
    import hyper_desc_pkg::*;
#(
    parameter int IRQ_DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic push,
    input  idx_t push_desc,
    input  logic pop,
    output logic pend,
    output idx_t head,
    output logic ovf
);

    localparam int PTR_W = $clog2(IRQ_DEPTH);

    idx_t             mem_q [IRQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             ovf_q;

    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(IRQ_DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign do_push = push && (!full || pop);

    // Storage holds data only; validity is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_desc;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (pop) begin
                ovf_q <= 1'b0;
            end else if (push && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign pend = !empty;
    assign head = empty ? '0 : mem_q[rd_ptr_q];
    assign ovf  = ovf_q;

endmodule

// File: rtl/hyper_desc_arbiter.sv
// -----------------------------------------------------------------------------
// hyper_desc_arbiter
// Owns the 8 x 64-bit DMA descriptor table and shares it between the
// scheduler (fixed-latency pipeline) and the CPU (req/ack handshake).
//   CLK   clock
//   RST   synchronous, active-low reset
//   bus   hyper_desc_arbiter_if.slave:
//         scheduler read  : S_READ/S_R_ADDR -> S_R_DATA (2 cycles)
//         scheduler write : S_WRITE/S_W_ADDR/S_W_DATA, committed one edge
//                           later only if the ownership bit still matches
//         scheduler irq   : S_IRQ/S_IRQ_DESC into the IRQ FIFO
//         CPU access      : C_REQ/C_WE/C_ADDR/C_WDATA -> C_ACK/C_RDATA
//         completion      : C_DONE bitmap, C_DONE_CLR clear mask
//         irq fifo        : C_IRQ_PEND/C_IRQ_DESC/C_IRQ_POP/C_IRQ_OVF
// Parameter IRQ_DEPTH: IRQ FIFO depth (power of two, 2..16).
// -----------------------------------------------------------------------------
module hyper_desc_arbiter
    import hyper_desc_pkg::*;
#(
    parameter int IRQ_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    hyper_desc_arbiter_if.slave bus
);

    desc_t   desc_q [DESC_ENTRIES];

    logic    rd_vld_p0;
    idx_t    rd_addr_p0;
    logic    wp_vld_p0;
    idx_t    wp_addr_p0;
    desc_t   wp_data_p0;

    desc_t   s_rdata_p1;
    logic    cpu_ack_p0;
    desc_t   cpu_rdata_p0;
    done_t   done_q;

    logic    wp_commit;
    done_t   done_set;
    cpu_op_e cpu_op;

    logic    irq_pend;
    idx_t    irq_head;
    logic    irq_ovf;

    // Write-back arbitration and CPU grant decode.
    // A pending scheduler write always owns the single table write port, so a
    // CPU write waits for an edge with an empty write stage. Reads are never
    // blocked. No grant while ACK is high gives the mandatory idle cycle.
    always_comb begin
        wp_commit = 1'b0;
        done_set  = '0;
        cpu_op    = CPU_NONE;
        if (wp_vld_p0 &&
            (desc_owner(wp_data_p0) == desc_owner(desc_q[wp_addr_p0]))) begin
            wp_commit = 1'b1;
            if (!desc_active(wp_data_p0)) begin
                done_set[wp_addr_p0] = 1'b1;
            end
        end
        if (bus.C_REQ && !cpu_ack_p0) begin
            if (!bus.C_WE) begin
                cpu_op = CPU_RD;
            end else if (!wp_vld_p0) begin
                cpu_op = CPU_WR;
            end
        end
    end

    // Stage p0: capture scheduler read/write strobes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_vld_p0  <= 1'b0;
            rd_addr_p0 <= '0;
            wp_vld_p0  <= 1'b0;
            wp_addr_p0 <= '0;
            wp_data_p0 <= '0;
        end else begin
            rd_vld_p0 <= bus.S_READ;
            if (bus.S_READ) begin
                rd_addr_p0 <= bus.S_R_ADDR;
            end
            wp_vld_p0 <= bus.S_WRITE;
            if (bus.S_WRITE) begin
                wp_addr_p0 <= bus.S_W_ADDR;
                wp_data_p0 <= bus.S_W_DATA;
            end
        end
    end

    // Stage p1: table write port (scheduler commit or granted CPU write).
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < DESC_ENTRIES; i++) begin
                desc_q[i] <= '0;
            end
        end else if (wp_commit) begin
            desc_q[wp_addr_p0] <= wp_data_p0;
        end else if (cpu_op == CPU_WR) begin
            desc_q[bus.C_ADDR] <= bus.C_WDATA;
        end
    end

    // Stage p1: scheduler read data; samples the table before this edge's
    // write, so a read landing on the commit edge returns the old value.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s_rdata_p1 <= '0;
        end else if (rd_vld_p0) begin
            s_rdata_p1 <= desc_q[rd_addr_p0];
        end
    end

    // CPU response and completion bitmap (set wins over clear).
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cpu_ack_p0   <= 1'b0;
            cpu_rdata_p0 <= '0;
            done_q       <= '0;
        end else begin
            cpu_ack_p0 <= (cpu_op != CPU_NONE);
            if (cpu_op == CPU_RD) begin
                cpu_rdata_p0 <= desc_q[bus.C_ADDR];
            end
            done_q <= (done_q & ~bus.C_DONE_CLR) | done_set;
        end
    end

    hyper_irq_fifo #(
        .IRQ_DEPTH (IRQ_DEPTH)
    ) u_irq_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (bus.S_IRQ),
        .push_desc (bus.S_IRQ_DESC),
        .pop       (bus.C_IRQ_POP),
        .pend      (irq_pend),
        .head      (irq_head),
        .ovf       (irq_ovf)
    );

    assign bus.S_R_DATA   = s_rdata_p1;
    assign bus.C_ACK      = cpu_ack_p0;
    assign bus.C_RDATA    = cpu_rdata_p0;
    assign bus.C_DONE     = done_q;
    assign bus.C_IRQ_PEND = irq_pend;
    assign bus.C_IRQ_DESC = irq_head;
    assign bus.C_IRQ_OVF  = irq_ovf;

endmodule

// File: tb/tb_hyper_desc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hyper_desc_arbiter
// Directed scenarios plus randomized traffic checked against a behavioural
// model of the descriptor table, completion bitmap and IRQ queue.
// -----------------------------------------------------------------------------
module tb_hyper_desc_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    hyper_desc_arbiter_if bus ();

    hyper_desc_arbiter #(
        .IRQ_DEPTH (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    logic [63:0] m_tab [8];
    bit          m_rd_v;
    logic [2:0]  m_rd_a;
    logic [63:0] m_srd;
    bit          m_wp_v;
    logic [2:0]  m_wp_a;
    logic [63:0] m_wp_d;
    bit          m_ack;
    bit          m_ack_rd;
    logic [63:0] m_crd;
    logic [7:0]  m_done;
    logic [2:0]  m_q [$];
    bit          m_ovf;

    task automatic clear_inputs();
        bus.S_READ     = 1'b0;
        bus.S_R_ADDR   = '0;
        bus.S_WRITE    = 1'b0;
        bus.S_W_ADDR   = '0;
        bus.S_W_DATA   = '0;
        bus.S_IRQ      = 1'b0;
        bus.S_IRQ_DESC = '0;
        bus.C_REQ      = 1'b0;
        bus.C_WE       = 1'b0;
        bus.C_ADDR     = '0;
        bus.C_WDATA    = '0;
        bus.C_DONE_CLR = '0;
        bus.C_IRQ_POP  = 1'b0;
    endtask

    // Advance one clock; the model applies the table/handshake/queue rules to
    // the inputs presented during the cycle that just ended.
    task automatic tick();
        logic [63:0] nt [8];
        logic [63:0] n_srd;
        logic [63:0] n_crd;
        logic [7:0]  n_done;
        bit          n_ack;
        bit          n_ack_rd;
        bit          commit;
        nt       = m_tab;
        n_srd    = m_srd;
        n_crd    = m_crd;
        n_done   = m_done;
        n_ack    = 1'b0;
        n_ack_rd = 1'b0;
        if (!RST) begin
            foreach (nt[i]) nt[i] = '0;
            n_srd  = '0;
            n_crd  = '0;
            n_done = '0;
            m_q.delete();
            m_ovf  = 1'b0;
        end else begin
            if (m_rd_v) n_srd = m_tab[m_rd_a];
            commit = m_wp_v && (m_wp_d[61] == m_tab[m_wp_a][61]);
            n_done = m_done & ~bus.C_DONE_CLR;
            if (commit) begin
                nt[m_wp_a] = m_wp_d;
                if (!m_wp_d[63]) n_done[m_wp_a] = 1'b1;
            end
            if (bus.C_REQ && !m_ack) begin
                if (!bus.C_WE) begin
                    n_ack    = 1'b1;
                    n_ack_rd = 1'b1;
                    n_crd    = m_tab[bus.C_ADDR];
                end else if (!m_wp_v) begin
                    n_ack = 1'b1;
                    nt[bus.C_ADDR] = bus.C_WDATA;
                end
            end
            if (bus.C_IRQ_POP) begin
                if (bus.S_IRQ && m_q.size() == 4) begin
                    void'(m_q.pop_front());
                    m_q.push_back(bus.S_IRQ_DESC);
                end else begin
                    if (m_q.size() > 0) void'(m_q.pop_front());
                    if (bus.S_IRQ) m_q.push_back(bus.S_IRQ_DESC);
                end
                m_ovf = 1'b0;
            end else if (bus.S_IRQ) begin
                if (m_q.size() == 4) m_ovf = 1'b1;
                else m_q.push_back(bus.S_IRQ_DESC);
            end
        end
        @(posedge CLK);
        #1;
        m_tab    = nt;
        m_srd    = n_srd;
        m_crd    = n_crd;
        m_done   = n_done;
        m_ack    = n_ack;
        m_ack_rd = n_ack_rd;
        m_rd_v   = RST && bus.S_READ;
        m_rd_a   = bus.S_R_ADDR;
        m_wp_v   = RST && bus.S_WRITE;
        m_wp_a   = bus.S_W_ADDR;
        m_wp_d   = bus.S_W_DATA;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.S_READ = 1'b1;
        bus.S_WRITE = 1'b1;
        bus.S_W_DATA = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.C_REQ = 1'b1;
        bus.S_IRQ = 1'b1;
        RST = 1'b0;
        tick();
        tick();
        n_total++; if (bus.S_R_DATA !== 64'h0) $display("FAIL reset_s_r_data got=%0h exp=0", bus.S_R_DATA); else n_pass++;
        n_total++; if (bus.C_ACK !== 1'b0) $display("FAIL reset_c_ack got=%0h exp=0", bus.C_ACK); else n_pass++;
        n_total++; if (bus.C_RDATA !== 64'h0) $display("FAIL reset_c_rdata got=%0h exp=0", bus.C_RDATA); else n_pass++;
        n_total++; if (bus.C_DONE !== 8'h00) $display("FAIL reset_c_done got=%0h exp=0", bus.C_DONE); else n_pass++;
        n_total++; if (bus.C_IRQ_PEND !== 1'b0) $display("FAIL reset_irq_pend got=%0h exp=0", bus.C_IRQ_PEND); else n_pass++;
        n_total++; if (bus.C_IRQ_DESC !== 3'd0) $display("FAIL reset_irq_desc got=%0h exp=0", bus.C_IRQ_DESC); else n_pass++;
        n_total++; if (bus.C_IRQ_OVF !== 1'b0) $display("FAIL reset_irq_ovf got=%0h exp=0", bus.C_IRQ_OVF); else n_pass++;
        clear_inputs();
        RST = 1'b1;
    endtask

    task automatic test_cpu_write_read();
        bus.C_REQ = 1'b1; bus.C_WE = 1'b1; bus.C_ADDR = 3'd0;
        bus.C_WDATA = 64'h9000_0080_0010_0001;
        tick();
        n_total++; if (bus.C_ACK !== 1'b1) $display("FAIL cpu_wr_ack got=%0h exp=1", bus.C_ACK); else n_pass++;
        bus.C_REQ = 1'b0;
        tick();
        n_total++; if (bus.C_ACK !== 1'b0) $display("FAIL cpu_ack_pulse got=%0h exp=0", bus.C_ACK); else n_pass++;
        bus.S_READ = 1'b1; bus.S_R_ADDR = 3'd0;
        tick();
        bus.S_READ = 1'b0;
        tick();
        n_total++; if (bus.S_R_DATA !== 64'h9000_0080_0010_0001) $display("FAIL sched_rd_e0 got=%0h exp=9000008000100001", bus.S_R_DATA); else n_pass++;
        bus.C_REQ = 1'b1; bus.C_WE = 1'b0; bus.C_ADDR = 3'd0;
        tick();
        n_total++; if (bus.C_ACK !== 1'b1) $display("FAIL cpu_rd_ack got=%0h exp=1", bus.C_ACK); else n_pass++;
        n_total++; if (bus.C_RDATA !== 64'h9000_0080_0010_0001) $display("FAIL cpu_rd_e0 got=%0h exp=9000008000100001", bus.C_RDATA); else n_pass++;
        bus.C_REQ = 1'b0;
        tick();
    endtask

    task automatic test_ownership();
        bus.C_REQ = 1'b1; bus.C_WE = 1'b1; bus.C_ADDR = 3'd1;
        bus.C_WDATA = 64'hA000_0000_0000_0011;
        tick();
        bus.C_REQ = 1'b0;
        tick();
        bus.S_WRITE = 1'b1; bus.S_W_ADDR = 3'd1; bus.S_W_DATA = 64'h1000_0000_0000_0000;
        tick();
        bus.S_WRITE = 1'b0;
        tick();
        bus.C_REQ = 1'b1; bus.C_WE = 1'b0; bus.C_ADDR = 3'd1;
        tick();
        n_total++; if (bus.C_RDATA !== 64'hA000_0000_0000_0011) $display("FAIL own_discard got=%0h exp=a000000000000011", bus.C_RDATA); else n_pass++;
        n_total++; if (bus.C_DONE !== 8'h00) $display("FAIL own_discard_done got=%0h exp=0", bus.C_DONE); else n_pass++;
        bus.C_REQ = 1'b0;
        tick();
        bus.S_WRITE = 1'b1; bus.S_W_ADDR = 3'd1; bus.S_W_DATA = 64'h2000_0000_0000_0000;
        tick();
        bus.S_WRITE = 1'b0;
        tick();
        n_total++; if (bus.C_DONE !== 8'h02) $display("FAIL own_commit_done got=%0h exp=2", bus.C_DONE); else n_pass++;
        bus.S_READ = 1'b1; bus.S_R_ADDR = 3'd1;
        tick();
        bus.S_READ = 1'b0;
        tick();
        n_total++; if (bus.S_R_DATA !== 64'h2000_0000_0000_0000) $display("FAIL own_commit_data got=%0h exp=2000000000000000", bus.S_R_DATA); else n_pass++;
        bus.C_DONE_CLR = 8'h02;
        tick();
        bus.C_DONE_CLR = 8'h00;
        n_total++; if (bus.C_DONE !== 8'h00) $display("FAIL done_clear got=%0h exp=0", bus.C_DONE); else n_pass++;
    endtask

    task automatic test_done_priority();
        bus.S_WRITE = 1'b1; bus.S_W_ADDR = 3'd1; bus.S_W_DATA = 64'h2000_0000_0000_0005;
        tick();
        bus.S_WRITE = 1'b0;
        bus.C_DONE_CLR = 8'h02;
        tick();
        bus.C_DONE_CLR = 8'h00;
        n_total++; if (bus.C_DONE !== 8'h02) $display("FAIL done_set_wins got=%0h exp=2", bus.C_DONE); else n_pass++;
        bus.C_DONE_CLR = 8'h02;
        tick();
        bus.C_DONE_CLR = 8'h00;
        n_total++; if (bus.C_DONE !== 8'h00) $display("FAIL done_clear2 got=%0h exp=0", bus.C_DONE); else n_pass++;
    endtask

    task automatic test_same_edge();
        bus.S_WRITE = 1'b1; bus.S_W_ADDR = 3'd3; bus.S_W_DATA = 64'h0000_0000_0000_3333;
        tick();
        bus.S_WRITE = 1'b0;
        bus.S_READ = 1'b1; bus.S_R_ADDR = 3'd3;
        bus.C_REQ = 1'b1; bus.C_WE = 1'b1; bus.C_ADDR = 3'd3;
        bus.C_WDATA = 64'h8000_0000_0000_CCCC;
        tick();
        bus.S_READ = 1'b0;
        n_total++; if (bus.C_ACK !== 1'b0) $display("FAIL same_edge_blocked got=%0h exp=0", bus.C_ACK); else n_pass++;
        tick();
        n_total++; if (bus.C_ACK !== 1'b1) $display("FAIL same_edge_ack_late got=%0h exp=1", bus.C_ACK); else n_pass++;
        n_total++; if (bus.S_R_DATA !== 64'h0000_0000_0000_3333) $display("FAIL same_edge_sched_first got=%0h exp=3333", bus.S_R_DATA); else n_pass++;
        n_total++; if (bus.C_DONE !== 8'h08) $display("FAIL same_edge_done got=%0h exp=8", bus.C_DONE); else n_pass++;
        bus.C_REQ = 1'b0;
        bus.S_READ = 1'b1; bus.S_R_ADDR = 3'd3;
        tick();
        bus.S_READ = 1'b0;
        tick();
        n_total++; if (bus.S_R_DATA !== 64'h8000_0000_0000_CCCC) $display("FAIL same_edge_cpu_last got=%0h exp=800000000000cccc", bus.S_R_DATA); else n_pass++;
        bus.C_DONE_CLR = 8'h08;
        tick();
        bus.C_DONE_CLR = 8'h00;
    endtask

    task automatic test_irq_fifo();
        for (int i = 1; i <= 5; i++) begin
            bus.S_IRQ = 1'b1; bus.S_IRQ_DESC = 3'(i);
            tick();
            if (i == 1) begin
                n_total++; if (bus.C_IRQ_PEND !== 1'b1) $display("FAIL irq_first_pend got=%0h exp=1", bus.C_IRQ_PEND); else n_pass++;
                n_total++; if (bus.C_IRQ_DESC !== 3'd1) $display("FAIL irq_first_desc got=%0h exp=1", bus.C_IRQ_DESC); else n_pass++;
            end
        end
        bus.S_IRQ = 1'b0;
        n_total++; if (bus.C_IRQ_OVF !== 1'b1) $display("FAIL irq_ovf_set got=%0h exp=1", bus.C_IRQ_OVF); else n_pass++;
        n_total++; if (bus.C_IRQ_DESC !== 3'd1) $display("FAIL irq_full_head got=%0h exp=1", bus.C_IRQ_DESC); else n_pass++;
        bus.C_IRQ_POP = 1'b1;
        tick();
        bus.C_IRQ_POP = 1'b0;
        n_total++; if (bus.C_IRQ_DESC !== 3'd2) $display("FAIL irq_pop_head got=%0h exp=2", bus.C_IRQ_DESC); else n_pass++;
        n_total++; if (bus.C_IRQ_OVF !== 1'b0) $display("FAIL irq_ovf_clr got=%0h exp=0", bus.C_IRQ_OVF); else n_pass++;
        bus.S_IRQ = 1'b1; bus.S_IRQ_DESC = 3'd6;
        tick();
        bus.S_IRQ_DESC = 3'd7; bus.C_IRQ_POP = 1'b1;
        tick();
        bus.S_IRQ = 1'b0;
        n_total++; if (bus.C_IRQ_DESC !== 3'd3) $display("FAIL irq_full_pushpop_head got=%0h exp=3", bus.C_IRQ_DESC); else n_pass++;
        n_total++; if (bus.C_IRQ_OVF !== 1'b0) $display("FAIL irq_full_pushpop_ovf got=%0h exp=0", bus.C_IRQ_OVF); else n_pass++;
        tick();
        n_total++; if (bus.C_IRQ_DESC !== 3'd4) $display("FAIL irq_drain_4 got=%0h exp=4", bus.C_IRQ_DESC); else n_pass++;
        tick();
        n_total++; if (bus.C_IRQ_DESC !== 3'd6) $display("FAIL irq_drain_6 got=%0h exp=6", bus.C_IRQ_DESC); else n_pass++;
        tick();
        n_total++; if (bus.C_IRQ_DESC !== 3'd7) $display("FAIL irq_drain_7 got=%0h exp=7", bus.C_IRQ_DESC); else n_pass++;
        tick();
        n_total++; if (bus.C_IRQ_PEND !== 1'b0) $display("FAIL irq_empty got=%0h exp=0", bus.C_IRQ_PEND); else n_pass++;
        tick();
        bus.C_IRQ_POP = 1'b0;
        n_total++; if (bus.C_IRQ_PEND !== 1'b0) $display("FAIL irq_pop_empty got=%0h exp=0", bus.C_IRQ_PEND); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        bus.S_IRQ = 1'b1; bus.S_IRQ_DESC = 3'd5;
        tick();
        bus.S_IRQ = 1'b0;
        bus.S_WRITE = 1'b1; bus.S_W_ADDR = 3'd4; bus.S_W_DATA = 64'h0000_0000_0000_0044;
        tick();
        bus.S_WRITE = 1'b0;
        RST = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        n_total++; if (bus.C_DONE !== 8'h00) $display("FAIL rst_mid_done got=%0h exp=0", bus.C_DONE); else n_pass++;
        n_total++; if (bus.C_IRQ_PEND !== 1'b0) $display("FAIL rst_mid_pend got=%0h exp=0", bus.C_IRQ_PEND); else n_pass++;
        n_total++; if (bus.C_ACK !== 1'b0) $display("FAIL rst_mid_ack got=%0h exp=0", bus.C_ACK); else n_pass++;
        // Back-to-back reads of every entry; each answer lands two cycles on.
        for (int k = 0; k < 10; k++) begin
            bus.S_READ = (k < 8);
            bus.S_R_ADDR = 3'(k);
            tick();
            if (k >= 1 && k <= 8) begin
                n_total++; if (bus.S_R_DATA !== 64'h0) $display("FAIL rst_mid_table entry=%0d got=%0h exp=0", k - 1, bus.S_R_DATA); else n_pass++;
            end
        end
        bus.S_READ = 1'b0;
    endtask

    task automatic test_random();
        clear_inputs();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            RST = ($urandom_range(0, 299) != 0);
            bus.S_READ     = $urandom_range(0, 1);
            bus.S_R_ADDR   = 3'($urandom_range(0, 7));
            bus.S_WRITE    = ($urandom_range(0, 2) == 0);
            bus.S_W_ADDR   = 3'($urandom_range(0, 7));
            bus.S_W_DATA   = {$urandom, $urandom};
            bus.S_IRQ      = ($urandom_range(0, 2) == 0);
            bus.S_IRQ_DESC = 3'($urandom_range(0, 7));
            bus.C_IRQ_POP  = ($urandom_range(0, 3) == 0);
            bus.C_DONE_CLR = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            if (!bus.C_REQ || bus.C_ACK) begin
                bus.C_REQ   = $urandom_range(0, 1);
                bus.C_WE    = $urandom_range(0, 1);
                bus.C_ADDR  = 3'($urandom_range(0, 7));
                bus.C_WDATA = {$urandom, $urandom};
            end
            tick();
            n_total++; if (bus.S_R_DATA !== m_srd) $display("FAIL rnd_s_r_data cyc=%0d got=%0h exp=%0h", cyc, bus.S_R_DATA, m_srd); else n_pass++;
            n_total++; if (bus.C_ACK !== m_ack) $display("FAIL rnd_c_ack cyc=%0d got=%0h exp=%0h", cyc, bus.C_ACK, m_ack); else n_pass++;
            if (m_ack && m_ack_rd) begin
                n_total++; if (bus.C_RDATA !== m_crd) $display("FAIL rnd_c_rdata cyc=%0d got=%0h exp=%0h", cyc, bus.C_RDATA, m_crd); else n_pass++;
            end
            n_total++; if (bus.C_DONE !== m_done) $display("FAIL rnd_c_done cyc=%0d got=%0h exp=%0h", cyc, bus.C_DONE, m_done); else n_pass++;
            n_total++; if (bus.C_IRQ_PEND !== (m_q.size() != 0)) $display("FAIL rnd_irq_pend cyc=%0d got=%0h exp=%0h", cyc, bus.C_IRQ_PEND, (m_q.size() != 0)); else n_pass++;
            if (m_q.size() != 0) begin
                n_total++; if (bus.C_IRQ_DESC !== m_q[0]) $display("FAIL rnd_irq_desc cyc=%0d got=%0h exp=%0h", cyc, bus.C_IRQ_DESC, m_q[0]); else n_pass++;
            end
            n_total++; if (bus.C_IRQ_OVF !== m_ovf) $display("FAIL rnd_irq_ovf cyc=%0d got=%0h exp=%0h", cyc, bus.C_IRQ_OVF, m_ovf); else n_pass++;
        end
        clear_inputs();
        RST = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_cpu_write_read();
        test_ownership();
        test_done_priority();
        test_same_edge();
        test_irq_fifo();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hyper_desc_arbiter.md
# hyper_desc_arbiter

Owns the 8-entry × 64-bit DMA descriptor table and shares it between hyper_scheduler and the CPU. The scheduler port keeps its fixed-latency read/write pipeline; CPU accesses use a req/ack handshake. Scheduler writes are gated by the ownership bit (bit 61) so that stale write-backs never clobber a descriptor the CPU has re-armed. The block also queues scheduler interrupt descriptors and keeps a completion bitmap for the CPU.

## Interface
- IRQ_DEPTH, 4: IRQ descriptor FIFO depth (power of two, 2..16).
- CLK  in  1  clock (CLK_n domain of the hyperfabric).
- RST  in  1  reset: synchronous, active-low.
- S_READ  in  1  scheduler read strobe.
- S_R_ADDR  in  3  scheduler read index.
- S_R_DATA  out  64  scheduler read data.
- S_WRITE  in  1  scheduler write strobe.
- S_W_ADDR  in  3  scheduler write index.
- S_W_DATA  in  64  scheduler write data.
- S_IRQ  in  1  interrupt strobe from scheduler.
- S_IRQ_DESC  in  3  interrupt descriptor.
- C_REQ  in  1  CPU request; held until C_ACK.
- C_WE  in  1  CPU write (1) / read (0); stable while C_REQ.
- C_ADDR  in  3  CPU table index.
- C_WDATA  in  64  CPU write data.
- C_ACK  out  1  one-cycle grant pulse.
- C_RDATA  out  64  CPU read data, valid with C_ACK.
- C_DONE  out  8  completion bitmap.
- C_DONE_CLR  in  8  per-bit clear mask, one cycle.
- C_IRQ_PEND  out  1  IRQ FIFO not empty.
- C_IRQ_DESC  out  3  FIFO head.
- C_IRQ_POP  in  1  drop FIFO head.
- C_IRQ_OVF  out  1  sticky overflow flag.

## Operation
- Table: 8 × 64 registers; two independent read ports (scheduler, CPU), one write port.
- Scheduler read: S_READ at edge E latches S_R_ADDR; at E+1 S_R_DATA <= table[addr]. S_R_DATA holds otherwise.
- Scheduler write: S_WRITE at edge E latches addr/data (stage wp). At E+1 commit iff wp_data[61] == table[wp_addr][61]; otherwise discard silently. Committed write with wp_data[63]==0 sets C_DONE[wp_addr].
- CPU read: C_REQ&!C_WE at edge E -> C_ACK=1, C_RDATA=table[C_ADDR] at E+1. Never blocked.
- CPU write: granted at an edge where no scheduler commit is pending (wp stage empty); table written at that edge, C_ACK=1 next cycle. Unconditional (no ownership check). Blocked while scheduler writes stream; no starvation guard.
- Same-edge scheduler commit and CPU write: scheduler wins, CPU retries next edge.
- After C_ACK, one idle cycle before a new CPU grant (C_REQ sampled again only after ACK falls).
- C_DONE: set has priority over C_DONE_CLR for the same bit in the same cycle.
- IRQ FIFO: S_IRQ pushes S_IRQ_DESC. Full and push without pop -> push dropped, C_IRQ_OVF=1. Push+pop when full -> both performed, no overflow. Pop when empty ignored. C_IRQ_OVF cleared by C_IRQ_POP.
- Reset (RST=0 at edge): all table entries 0, every output 0, FIFO empty, pending scheduler write and CPU transaction discarded.

## Timing
- Scheduler read latency: data valid 2 cycles after S_READ cycle (strobe cycle T, data from T+2).
- Scheduler write visible to either read port from the cycle after commit (T+2); read launched same edge as commit sees old value.
- CPU read latency 1 cycle; CPU write latency ≥1 cycle.
- C_IRQ_PEND/C_IRQ_DESC update the cycle after push/pop; first push visible at T+1.
- Back-to-back S_READ/S_WRITE every cycle supported, no bubbles.

## Structure
- Shared package hyper_desc_pkg: DESC_ACTIVE_BIT=63, DESC_OWN_BIT=61, DESC_ENTRIES=8, descriptor width 64.
- Sub-module hyper_irq_fifo (push/pop/pend/head/overflow, parameter IRQ_DEPTH); rest flat.

## Test plan
- CPU writes 64'h9000_0080_0010_0001 to entry 0 -> C_ACK next cycle; S_READ addr 0 returns it on S_R_DATA two cycles later.
- Entry 1 bit61=1; scheduler writes 64'h1000_0000_0000_0000 (bit61=0) -> discarded, entry unchanged; write 64'h2000_..._0000 (bit61=1, bit63=0) -> committed, C_DONE=8'h02.
- Scheduler write and CPU write to entry 3 same edge -> scheduler value lands first, CPU value overwrites one edge later, C_ACK delayed by 1.
- Five S_IRQ pulses descs 1..5 with no pops, IRQ_DEPTH=4 -> FIFO holds 1,2,3,4, C_IRQ_OVF=1; pop -> head 2, OVF=0.
- C_DONE_CLR=8'h02 coincident with completion on entry 1 -> bit stays 1.
- RST low mid scheduler write -> table all zero, outputs zero, no commit after release.
